// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard/stall bundle: ID-stage instruction info in, pipeline
// control enables and status out.
// Handshake: none. The ID fields are sampled every cycle and qualified by
// id_valid. The outputs are combinational controls for the current cycle.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_rs_valid;
  logic             id_rt_valid;
  logic [2:0]       id_write_reg;
  logic             id_reg_write;
  logic             id_halt;
  logic             ex_redirect;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             control_zero;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic             state_dbg;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_valid, id_rt_valid,
           id_write_reg, id_reg_write, id_halt, ex_redirect,
    input  pc_write, ifid_write, ifid_flush, control_zero, halted,
           stall_count, state_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_valid, id_rt_valid,
           id_write_reg, id_reg_write, id_halt, ex_redirect,
    output pc_write, ifid_write, ifid_flush, control_zero, halted,
           stall_count, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller beside the decode stage. It keeps a shadow of
// the in-flight destination registers for EX/MEM/WB and stalls RAW readers.
// It also flushes on EX redirects and freezes the core after HALT issues.
module hazard_ctrl #(
  parameter int TRACK_STAGES = 3,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       slot_valid;        // [0]=EX, [1]=MEM, [2]=WB
  logic [2:0][2:0]  slot_reg;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             rs_match, rt_match, hazard;
  logic             issue, cnt_inc, push_valid;

  // Compare the ID sources against the tracked in-flight destinations.
  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int k = 0; k < TRACK_STAGES; k++) begin
      if (slot_valid[k] && (slot_reg[k] == bus.id_rs)) rs_match = 1'b1;
      if (slot_valid[k] && (slot_reg[k] == bus.id_rt)) rt_match = 1'b1;
    end
  end

  assign hazard = bus.id_valid &
                  ((bus.id_rs_valid & rs_match) | (bus.id_rt_valid & rt_match));

  // Next state and pipeline controls. In RUN the priority is redirect, then hazard, then halt.
  always_comb begin
    state_d          = state_q;
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.control_zero = 1'b0;
    bus.halted       = 1'b0;
    issue            = 1'b0;
    cnt_inc          = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_redirect) begin
          // Wrong-path ID instruction is squashed, including a HALT.
          bus.ifid_flush   = 1'b1;
          bus.control_zero = 1'b1;
        end else if (hazard) begin
          bus.control_zero = 1'b1;
          bus.pc_write     = 1'b0;
          bus.ifid_write   = 1'b0;
          cnt_inc          = 1'b1;
        end else begin
          issue = 1'b1;
          if (bus.id_valid && bus.id_halt) state_d = HALTED;
        end
      end
      HALTED: begin
        bus.halted       = 1'b1;
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.control_zero = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // A HALT never writes a register, so it enters the shadow as a bubble.
  assign push_valid = issue & bus.id_valid & bus.id_reg_write & ~bus.id_halt;

  // State register, slot shift register and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      slot_valid  <= '0;
      slot_reg    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_valid <= {slot_valid[1:0], push_valid};
      slot_reg   <= {slot_reg[1:0], bus.id_write_reg};
      if (cnt_inc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.state_dbg   = (state_q == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the stimulus: a
// 16-bit counter instance for the functional checks and a 4-bit counter
// instance for the saturation check.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  logic [31:0] exp_q[$];

  hazard_ctrl_if #(.CNT_W(16)) ifc ();
  hazard_ctrl_if #(.CNT_W(4))  ifc4 ();

  hazard_ctrl #(.TRACK_STAGES(3), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  hazard_ctrl #(.TRACK_STAGES(3), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vectors: {pc_write, ifid_write, ifid_flush, control_zero, halted}.
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_REDIR = 5'b11110;
  localparam logic [4:0] O_HALT  = 5'b00011;

  // Driver tasks.
  task automatic drive(input logic v, input logic [2:0] rs, input logic rsv,
                       input logic [2:0] rt, input logic rtv, input logic [2:0] wr,
                       input logic rw, input logic hlt, input logic redir);
    ifc.id_valid = v;       ifc4.id_valid = v;
    ifc.id_rs = rs;         ifc4.id_rs = rs;
    ifc.id_rs_valid = rsv;  ifc4.id_rs_valid = rsv;
    ifc.id_rt = rt;         ifc4.id_rt = rt;
    ifc.id_rt_valid = rtv;  ifc4.id_rt_valid = rtv;
    ifc.id_write_reg = wr;  ifc4.id_write_reg = wr;
    ifc.id_reg_write = rw;  ifc4.id_reg_write = rw;
    ifc.id_halt = hlt;      ifc4.id_halt = hlt;
    ifc.ex_redirect = redir; ifc4.ex_redirect = redir;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic writer(input logic [2:0] wr);
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, wr, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reader_rs(input logic [2:0] rs, input logic redir);
    drive(1'b1, rs, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, redir);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard checks.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, ifc.pc_write, ifc.ifid_write, ifc.ifid_flush,
              ifc.control_zero, ifc.halted}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset values while rst is held.
    chk_out("reset_outputs", O_NORM);
    chk("reset_count", {16'd0, ifc.stall_count}, 32'd0);
    chk("reset_state", {31'd0, ifc.state_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // RAW hazard: writer r3, then a reader of r3 stalls exactly 3 cycles.
    writer(3'd3);
    chk_out("raw_writer_issue", O_NORM);
    tick();
    reader_rs(3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("raw_stall_%0d", i), O_STALL);
      tick();
    end
    chk_out("raw_reader_issue", O_NORM);
    tick();
    chk("raw_count", {16'd0, ifc.stall_count}, 32'd3);

    // No false hazard: the writer does not write the register file.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    reader_rs(3'd2, 1'b0);
    chk_out("nofalse_regwrite0", O_NORM);
    tick();
    // No false hazard: rt matches a real writer but rt is not read.
    writer(3'd2);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk_out("nofalse_rt_invalid", O_NORM);
    tick();
    // rt is read and matches the in-flight r2, so this reader stalls.
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    chk_out("rt_hazard", O_STALL);
    tick();
    chk("rt_hazard_count", {16'd0, ifc.stall_count}, 32'd4);
    idle();
    tick();

    // A redirect during a stall wins, and that cycle does not count as a stall.
    writer(3'd5);
    tick();
    reader_rs(3'd5, 1'b0);
    chk_out("redir_pre_stall", O_STALL);
    tick();
    chk("redir_pre_count", {16'd0, ifc.stall_count}, 32'd5);
    reader_rs(3'd5, 1'b1);
    chk_out("redir_wins", O_REDIR);
    tick();
    chk("redir_count_held", {16'd0, ifc.stall_count}, 32'd5);
    idle();
    chk_out("drain_idle", O_NORM);
    tick(); tick(); tick();

    // Asynchronous reset mid-cycle while a slot is valid.
    writer(3'd6);
    tick();
    reader_rs(3'd6, 1'b0);
    chk_out("pre_reset_stall", O_STALL);
    rst = 1'b1;
    #1;
    chk_out("async_reset_outputs", O_NORM);
    chk("async_reset_count", {16'd0, ifc.stall_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk_out("post_reset_no_stall", O_NORM);
    tick();

    // HALT freeze: redirects and hazards are ignored afterwards.
    writer(3'd7);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk_out("halt_issue", O_NORM);
    tick();
    idle();
    chk_out("halted_idle", O_HALT);
    chk("halted_state", {31'd0, ifc.state_dbg}, 32'd1);
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk_out("halted_redirect", O_HALT);
    tick();
    reader_rs(3'd7, 1'b0);
    chk_out("halted_hazard", O_HALT);
    tick();
    chk("halted_count", {16'd0, ifc.stall_count}, 32'd0);
    chk_out("halted_stays", O_HALT);
    rst = 1'b1;
    #1;
    chk_out("halt_reset", O_NORM);
    chk("halt_reset_state", {31'd0, ifc.state_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Saturation: 7 writer/reader pairs produce 21 stall cycles.
    for (int p = 0; p < 7; p++) begin
      writer(3'd1);
      tick();
      reader_rs(3'd1, 1'b0);
      for (int s = 0; s < 3; s++) begin
        chk_out("sat_stall", O_STALL);
        tick();
      end
      chk_out("sat_issue", O_NORM);
      tick();
      exp_q.push_back((3 * (p + 1) > 15) ? 32'd15 : 32'(3 * (p + 1)));
      chk("sat_count4", {28'd0, ifc4.stall_count}, exp_q.pop_front());
    end
    chk("count16_no_sat", {16'd0, ifc.stall_count}, 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
